// File: rtl/reset_sequencer.sv
// Board reset generator: power-on hold, PLL-lock filter, staged release
// of NUM_CHANNELS active-low domain resets, ordered re-reset, lock-loss abort.
// Ports:
//   clk           system clock
//   resetn        synchronous active-low reset
//   pll_locked    PLL lock, synchronous to clk
//   sw_reset_req  1-cycle pulse requesting an ordered re-reset
//   chan_resetn   per-domain active-low resets (registered)
//   all_released  high only in RUN (registered)
//   state_o       current FSM state (debug)
module reset_sequencer #(
   parameter int NUM_CHANNELS = 4,
   parameter int POR_CYCLES   = 200,
   parameter int LOCK_FILTER  = 8,
   parameter int STAGE_DELAY  = 16
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    pll_locked,
   input  logic                    sw_reset_req,
   output logic [NUM_CHANNELS-1:0] chan_resetn,
   output logic                    all_released,
   output logic [2:0]              state_o
);

   localparam int PW = $clog2(POR_CYCLES + 1);
   localparam int LW = $clog2(LOCK_FILTER + 1);
   localparam int DW = (STAGE_DELAY > 0) ?
                       $clog2(STAGE_DELAY + 1) : 1;
   localparam int SW = (NUM_CHANNELS > 1) ?
                       $clog2(NUM_CHANNELS) : 1;

   localparam logic [PW-1:0] POR_INIT = PW'(POR_CYCLES);
   localparam logic [DW-1:0] DLY_INIT = DW'(STAGE_DELAY);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_FILTER - 1);
   localparam logic [SW-1:0] STG_LAST = SW'(NUM_CHANNELS - 1);
   localparam logic [SW-1:0] STG_DRAIN =
      SW'((NUM_CHANNELS > 1) ? NUM_CHANNELS - 2 : 0);

   typedef enum logic [2:0] {
      S_POR   = 3'd0,
      S_LOCK  = 3'd1,
      S_SEQ   = 3'd2,
      S_RUN   = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   // Power-up values match the reset values so the POR hold
   // runs on an FPGA without any resetn pulse.
   state_t                  state_q = S_POR;
   state_t                  state_d;
   logic [PW-1:0]           por_q   = POR_INIT;
   logic [PW-1:0]           por_d;
   logic [LW-1:0]           lock_q  = '0;
   logic [LW-1:0]           lock_d;
   logic [SW-1:0]           stage_q = '0;
   logic [SW-1:0]           stage_d;
   logic [DW-1:0]           dly_q   = '0;
   logic [DW-1:0]           dly_d;
   logic [NUM_CHANNELS-1:0] chan_q  = '0;
   logic [NUM_CHANNELS-1:0] chan_d;
   logic                    rel_q   = 1'b0;
   logic                    rel_d;
   logic [NUM_CHANNELS-1:0] stage_oh;

   always_comb begin
      stage_oh = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         stage_oh[i] = (stage_q == SW'(i));
      end
   end

   always_comb begin
      state_d = state_q;
      por_d   = por_q;
      lock_d  = lock_q;
      stage_d = stage_q;
      dly_d   = dly_q;
      chan_d  = chan_q;
      rel_d   = rel_q;
      case (state_q)
         S_POR: begin
            if (por_q != '0) begin
               por_d = por_q - 1'b1;
            end else begin
               state_d = S_LOCK;
            end
         end
         S_LOCK: begin
            if (!pll_locked) begin
               lock_d = '0;
            end else if (lock_q == LOCK_LAST) begin
               state_d = S_SEQ;
               lock_d  = '0;
               stage_d = '0;
               dly_d   = DLY_INIT;
            end else begin
               lock_d = lock_q + 1'b1;
            end
         end
         S_SEQ: begin
            if (!pll_locked) begin
               state_d = S_LOCK;
               lock_d  = '0;
               chan_d  = '0;
               rel_d   = 1'b0;
            end else if (dly_q != '0) begin
               dly_d = dly_q - 1'b1;
            end else begin
               chan_d = chan_q | stage_oh;
               if (stage_q == STG_LAST) begin
                  state_d = S_RUN;
                  rel_d   = 1'b1;
               end else begin
                  stage_d = stage_q + 1'b1;
                  dly_d   = DLY_INIT;
               end
            end
         end
         S_RUN: begin
            if (!pll_locked) begin
               state_d = S_LOCK;
               lock_d  = '0;
               chan_d  = '0;
               rel_d   = 1'b0;
            end else if (sw_reset_req) begin
               rel_d = 1'b0;
               if (NUM_CHANNELS == 1) begin
                  state_d = S_LOCK;
                  lock_d  = '0;
                  chan_d  = '0;
               end else begin
                  // Last-released domain goes down first.
                  state_d = S_DRAIN;
                  chan_d[NUM_CHANNELS-1] = 1'b0;
                  stage_d = STG_DRAIN;
                  dly_d   = DLY_INIT;
               end
            end
         end
         S_DRAIN: begin
            if (!pll_locked) begin
               state_d = S_LOCK;
               lock_d  = '0;
               chan_d  = '0;
               rel_d   = 1'b0;
            end else if (dly_q != '0) begin
               dly_d = dly_q - 1'b1;
            end else begin
               chan_d = chan_q & ~stage_oh;
               if (stage_q == '0) begin
                  state_d = S_LOCK;
                  lock_d  = '0;
               end else begin
                  stage_d = stage_q - 1'b1;
                  dly_d   = DLY_INIT;
               end
            end
         end
         default: begin
            state_d = S_POR;
            por_d   = POR_INIT;
            lock_d  = '0;
            stage_d = '0;
            dly_d   = '0;
            chan_d  = '0;
            rel_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_POR;
         por_q   <= POR_INIT;
         lock_q  <= '0;
         stage_q <= '0;
         dly_q   <= '0;
         chan_q  <= '0;
         rel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         por_q   <= por_d;
         lock_q  <= lock_d;
         stage_q <= stage_d;
         dly_q   <= dly_d;
         chan_q  <= chan_d;
         rel_q   <= rel_d;
      end
   end

   assign chan_resetn  = chan_q;
   assign all_released = rel_q;
   assign state_o      = state_q;

endmodule
